// File: rtl/ftdi_cmd_decoder_if.sv
// Byte-stream and register-bus bundle between the FTDI bridge, the command
// decoder and the register file. master = decoder side, slave = environment side.
interface ftdi_cmd_decoder_if;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  s_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [7:0]  m_tdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  modport master (
    input  s_tvalid, s_tdata, m_tready, reg_rdata,
    output s_tready, m_tvalid, m_tdata, reg_wr, reg_rd, reg_addr, reg_wdata
  );

  modport slave (
    output s_tvalid, s_tdata, m_tready, reg_rdata,
    input  s_tready, m_tvalid, m_tdata, reg_wr, reg_rd, reg_addr, reg_wdata
  );
endinterface

// File: rtl/ftdi_cmd_decoder.sv
// Host frame parser: 55 01 A D0..D3 CHK (write) / 55 02 A CHK (read) into
// single-cycle register strokes, with AA-prefixed response frames back to the host.
module ftdi_cmd_decoder #(
  parameter int TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  ftdi_cmd_decoder_if.master  bus,
  output logic [7:0]          err_cnt
);
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {HUNT, CMD, ADDR, DATA, CHK, EXEC, RDWAIT, RESP} state_t;
  state_t state, nxt;

  logic          cmd_wr;
  logic [7:0]    chk, code, addr_q;
  logic [1:0]    didx;
  logic [2:0]    ridx, rlen;
  logic [31:0]   rdata_q, wdata_q;
  logic [IW-1:0] idle;
  logic          in_frame, acc, tmo, txd, chk_ok, bad_cmd, err_now;

  assign in_frame = (state == CMD) || (state == ADDR) || (state == DATA) || (state == CHK);
  assign acc      = bus.s_tvalid & bus.s_tready;
  assign txd      = bus.m_tvalid & bus.m_tready;
  assign tmo      = in_frame & ~acc & (idle == IW'(TIMEOUT - 1));
  assign chk_ok   = (bus.s_tdata == chk);
  assign bad_cmd  = (bus.s_tdata != 8'h55) && (bus.s_tdata != 8'h01) && (bus.s_tdata != 8'h02);
  assign err_now  = acc & (((state == CMD) & bad_cmd) | ((state == CHK) & ~chk_ok));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= HUNT;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      HUNT:   if (acc && bus.s_tdata == 8'h55) nxt = CMD;
      CMD:    if (acc) nxt = (bus.s_tdata == 8'h55) ? CMD : (bad_cmd ? RESP : ADDR);
      ADDR:   if (acc) nxt = cmd_wr ? DATA : CHK;
      DATA:   if (acc && didx == 2'd3) nxt = CHK;
      CHK:    if (acc) nxt = chk_ok ? EXEC : RESP;
      EXEC:   nxt = cmd_wr ? RESP : RDWAIT;
      RDWAIT: nxt = RESP;
      RESP:   if (txd && ridx == rlen - 3'd1) nxt = HUNT;
      default: nxt = HUNT;
    endcase
    if (tmo) nxt = HUNT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      idle    <= '0;
      cmd_wr  <= 1'b0;
      chk     <= '0;
      code    <= '0;
      addr_q  <= '0;
      didx    <= '0;
      ridx    <= '0;
      rlen    <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
    end else begin
      if ((err_now || tmo) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      idle <= (in_frame && !acc) ? idle + 1'b1 : '0;
      if (acc) begin
        case (state)
          HUNT, CMD: begin
            // SYNC (first or repeated) restarts the checksum; a command byte seeds it
            chk <= (state == HUNT || bus.s_tdata == 8'h55) ? 8'h00 : bus.s_tdata;
            if (state == CMD) cmd_wr <= (bus.s_tdata == 8'h01);
          end
          ADDR: begin
            addr_q <= bus.s_tdata;
            chk    <= chk ^ bus.s_tdata;
            didx   <= '0;
          end
          DATA: begin
            wdata_q[{didx, 3'b000} +: 8] <= bus.s_tdata;
            chk  <= chk ^ bus.s_tdata;
            didx <= didx + 2'd1;
          end
          default: ;
        endcase
      end
      if (err_now) begin
        code <= 8'hEE; rlen <= 3'd2; ridx <= '0;
      end else if (state == EXEC && cmd_wr) begin
        code <= 8'h01; rlen <= 3'd2; ridx <= '0;
      end else if (state == RDWAIT) begin
        rdata_q <= bus.reg_rdata;
        code <= 8'h02; rlen <= 3'd6; ridx <= '0;
      end else if (state == RESP && txd) begin
        ridx <= ridx + 3'd1;
      end
    end
  end

  always_comb begin
    bus.s_tready  = in_frame || (state == HUNT);
    bus.m_tvalid  = (state == RESP);
    bus.m_tdata   = 8'h00;
    if (state == RESP) begin
      case (ridx)
        3'd0:    bus.m_tdata = 8'hAA;
        3'd1:    bus.m_tdata = code;
        3'd2:    bus.m_tdata = rdata_q[7:0];
        3'd3:    bus.m_tdata = rdata_q[15:8];
        3'd4:    bus.m_tdata = rdata_q[23:16];
        3'd5:    bus.m_tdata = rdata_q[31:24];
        default: bus.m_tdata = 8'h00;
      endcase
    end
    bus.reg_wr    = (state == EXEC) &&  cmd_wr;
    bus.reg_rd    = (state == EXEC) && !cmd_wr;
    bus.reg_addr  = addr_q;
    bus.reg_wdata = wdata_q;
  end
endmodule
